// File: rtl/prim_chain_pkg.sv
// prim_chain_pkg
// Shared definitions for the XOR/NOT primitive chain test controller:
//   state_e       - controller FSM states
//   MAX_W         - widest chain vector the golden function handles
//   golden_chain  - closed-form expected chain output for a given depth
package prim_chain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_e;

    localparam int MAX_W = 64;

    // Pair p occupies bits {2p+1 (hi), 2p (lo)}. One stage is
    // hi' = hi ^ lo, lo' = ~lo, so the chain repeats with period 4:
    //   0: (hi, lo)   1: (hi^lo, ~lo)   2: (~hi, lo)   3: (~(hi^lo), ~lo)
    function automatic logic [MAX_W-1:0] golden_chain(
        input logic [MAX_W-1:0] vec,
        input int               io_pairs,
        input int               depth
    );
        logic [MAX_W-1:0] res;
        logic             hi;
        logic             lo;
        res = vec;
        for (int p = 0; p < MAX_W / 2; p++) begin
            if (p < io_pairs) begin
                hi = vec[2*p+1];
                lo = vec[2*p];
                case (depth % 4)
                    1: begin
                        res[2*p+1] = hi ^ lo;
                        res[2*p]   = ~lo;
                    end
                    2: begin
                        res[2*p+1] = ~hi;
                        res[2*p]   = lo;
                    end
                    3: begin
                        res[2*p+1] = ~(hi ^ lo);
                        res[2*p]   = ~lo;
                    end
                    default: begin
                        res[2*p+1] = hi;
                        res[2*p]   = lo;
                    end
                endcase
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/prim_chain_golden.sv
// prim_chain_golden
// Combinational expected-value generator for a chain of DEPTH stages.
// Ports:
//   vec_i  - chain input vector (2*IO_PAIRS bits)
//   gold_o - expected chain output for vec_i
module prim_chain_golden
    import prim_chain_pkg::*;
#(
    parameter int IO_PAIRS = 7,
    parameter int DEPTH    = 1
) (
    input  logic [2*IO_PAIRS-1:0] vec_i,
    output logic [2*IO_PAIRS-1:0] gold_o
);

    localparam int W = 2 * IO_PAIRS;

    assign gold_o = W'(golden_chain(MAX_W'(vec_i), IO_PAIRS, DEPTH));

endmodule

// File: rtl/prim_chain_test_ctrl.sv
// prim_chain_test_ctrl
// Drives index vectors 0..NUM_VECTORS-1 into a combinational XOR/NOT chain,
// waits SETTLE_CYCLES, compares the chain output with the golden model and
// records the number of failing vectors and the first failing index.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   start           - begin a run (accepted only in IDLE)
//   dut_in          - stimulus to the chain input
//   dut_out         - chain output
//   busy            - run in progress (DRIVE of vector 0 .. last CHECK)
//   done            - one-cycle pulse at the end of a run
//   mismatch_count  - failing vectors in the last run
//   fail_valid      - at least one failure in the last run
//   first_fail      - index of the first failing vector
module prim_chain_test_ctrl
    import prim_chain_pkg::*;
#(
    parameter  int IO_PAIRS      = 7,
    parameter  int DEPTH         = 1,
    parameter  int NUM_VECTORS   = 256,
    parameter  int SETTLE_CYCLES = 2,
    localparam int W             = 2 * IO_PAIRS,
    localparam int MC_W          = $clog2(NUM_VECTORS + 1),
    localparam int IDX_W         = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [W-1:0]     dut_in,
    input  logic [W-1:0]     dut_out,
    output logic             busy,
    output logic             done,
    output logic [MC_W-1:0]  mismatch_count,
    output logic             fail_valid,
    output logic [IDX_W-1:0] first_fail
);

    localparam int CNT_W       = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    // SETTLE lasts load+1 cycles because the exit test is on zero.
    localparam int SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     dut_in_q, dut_in_d;
    logic [MC_W-1:0]  mc_q, mc_d;
    logic             fv_q, fv_d;
    logic [IDX_W-1:0] ff_q, ff_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [W-1:0]     gold;
    logic             mismatch;

    prim_chain_golden #(
        .IO_PAIRS (IO_PAIRS),
        .DEPTH    (DEPTH)
    ) u_golden (
        .vec_i  (dut_in_q),
        .gold_o (gold)
    );

    assign mismatch = (dut_out != gold);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            dut_in_q <= '0;
            mc_q     <= '0;
            fv_q     <= 1'b0;
            ff_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            dut_in_q <= dut_in_d;
            mc_q     <= mc_d;
            fv_q     <= fv_d;
            ff_q     <= ff_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        dut_in_d = dut_in_q;
        mc_d     = mc_q;
        fv_d     = fv_q;
        ff_d     = ff_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_DRIVE;
                    idx_d    = '0;
                    dut_in_d = '0;
                    mc_d     = '0;
                    fv_d     = 1'b0;
                    ff_d     = '0;
                end
            end
            ST_DRIVE: begin
                cnt_d   = CNT_W'(SETTLE_LOAD);
                state_d = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_CHECK;
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    mc_d = mc_q + MC_W'(1);
                    if (!fv_q) begin
                        fv_d = 1'b1;
                        ff_d = idx_q;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d    = idx_q + IDX_W'(1);
                    // Register the next stimulus so it is stable for the whole DRIVE cycle.
                    dut_in_d = W'(idx_d);
                    state_d  = ST_DRIVE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_d = (state_d == ST_DRIVE) || (state_d == ST_SETTLE) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
    end

    assign dut_in         = dut_in_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign mismatch_count = mc_q;
    assign fail_valid     = fv_q;
    assign first_fail     = ff_q;

endmodule

// File: tb/tb_prim_chain_test_ctrl.sv
module tb_prim_chain_test_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic rst;
    logic start_a, start_b, start_c, start_d;
    logic [13:0] din_a, din_b, din_c, din_d;
    logic [13:0] dout_a, dout_b, dout_c, dout_d;
    logic busy_a, busy_b, busy_c, busy_d;
    logic done_a, done_b, done_c, done_d;
    logic fv_a, fv_b, fv_c, fv_d;
    logic [4:0] mc_a;
    logic [3:0] ff_a;
    logic [2:0] mc_b;
    logic [1:0] ff_b;
    logic [8:0] mc_c;
    logic [7:0] ff_c;
    logic [1:0] mc_d;
    logic [1:0] ff_d;
    int fault_a = -1;

    logic [13:0] g_in;
    logic [13:0] g2_out, g3_out;

    // Reference chain built stage by stage: hi' = hi ^ lo, lo' = ~lo.
    function automatic logic [13:0] chain_model(input logic [13:0] v, input int depth);
        logic [13:0] r;
        logic hi, lo;
        r = v;
        for (int d = 0; d < depth; d++) begin
            for (int p = 0; p < 7; p++) begin
                hi = r[2*p+1];
                lo = r[2*p];
                r[2*p+1] = hi ^ lo;
                r[2*p]   = ~lo;
            end
        end
        return r;
    endfunction

    assign dout_a = chain_model(din_a, 1) ^
                    ((fault_a >= 0 && int'(din_a) == fault_a) ? 14'h0001 : 14'h0000);
    assign dout_b = chain_model(din_b, 1) & ~14'h0002;
    assign dout_c = chain_model(din_c, 2);
    assign dout_d = chain_model(din_d, 1);

    prim_chain_test_ctrl #(.IO_PAIRS(7), .DEPTH(1), .NUM_VECTORS(16), .SETTLE_CYCLES(2)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .dut_in(din_a), .dut_out(dout_a),
        .busy(busy_a), .done(done_a), .mismatch_count(mc_a), .fail_valid(fv_a), .first_fail(ff_a));

    prim_chain_test_ctrl #(.IO_PAIRS(7), .DEPTH(1), .NUM_VECTORS(4), .SETTLE_CYCLES(2)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .dut_in(din_b), .dut_out(dout_b),
        .busy(busy_b), .done(done_b), .mismatch_count(mc_b), .fail_valid(fv_b), .first_fail(ff_b));

    prim_chain_test_ctrl #(.IO_PAIRS(7), .DEPTH(2), .NUM_VECTORS(256), .SETTLE_CYCLES(2)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .dut_in(din_c), .dut_out(dout_c),
        .busy(busy_c), .done(done_c), .mismatch_count(mc_c), .fail_valid(fv_c), .first_fail(ff_c));

    prim_chain_test_ctrl #(.IO_PAIRS(7), .DEPTH(1), .NUM_VECTORS(3), .SETTLE_CYCLES(0)) u_d (
        .clk(clk), .rst(rst), .start(start_d), .dut_in(din_d), .dut_out(dout_d),
        .busy(busy_d), .done(done_d), .mismatch_count(mc_d), .fail_valid(fv_d), .first_fail(ff_d));

    prim_chain_golden #(.IO_PAIRS(7), .DEPTH(2)) u_gold2 (.vec_i(g_in), .gold_o(g2_out));
    prim_chain_golden #(.IO_PAIRS(7), .DEPTH(3)) u_gold3 (.vec_i(g_in), .gold_o(g3_out));

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (din_a !== 14'h0 || busy_a !== 1'b0 || done_a !== 1'b0 || mc_a !== 5'd0 ||
            fv_a !== 1'b0 || ff_a !== 4'd0) begin
            errors++;
            $display("FAIL reset_a: dut_in=%0h busy=%b done=%b mc=%0d fv=%b ff=%0d, expected all zero",
                     din_a, busy_a, done_a, mc_a, fv_a, ff_a);
        end
        checks++;
        if (din_d !== 14'h0 || busy_d !== 1'b0 || done_d !== 1'b0 || mc_d !== 2'd0) begin
            errors++;
            $display("FAIL reset_d: dut_in=%0h busy=%b done=%b mc=%0d, expected all zero",
                     din_d, busy_d, done_d, mc_d);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_run_a(input int exp_mc, input int exp_ff, input bit exp_fv, input string tag);
        int done_cyc;
        int pulses;
        done_cyc = -1;
        pulses = 0;
        start_a = 1'b1;
        for (int c = 1; c <= 72; c++) begin
            @(negedge clk);
            if (c == 1) start_a = 1'b0;
            if (done_a === 1'b1) begin
                pulses++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (c == 1) begin
                checks++;
                if (busy_a !== 1'b1 || din_a !== 14'd0) begin
                    errors++;
                    $display("FAIL %s drive0: busy=%b dut_in=%0h, expected busy=1 dut_in=0", tag, busy_a, din_a);
                end
            end
            if (c == 5) begin
                checks++;
                if (din_a !== 14'd1) begin
                    errors++;
                    $display("FAIL %s drive1: dut_in=%0h, expected 1", tag, din_a);
                end
            end
            if (c == 64 || c == 65) begin
                checks++;
                if (busy_a !== (c == 64)) begin
                    errors++;
                    $display("FAIL %s busy_c%0d: busy=%b, expected %b", tag, c, busy_a, (c == 64));
                end
            end
        end
        checks++;
        if (done_cyc != 65 || pulses != 1) begin
            errors++;
            $display("FAIL %s done_timing: first done cycle=%0d pulses=%0d, expected cycle 65 pulses 1",
                     tag, done_cyc, pulses);
        end
        checks++;
        if (mc_a !== 5'(exp_mc) || ff_a !== 4'(exp_ff) || fv_a !== exp_fv) begin
            errors++;
            $display("FAIL %s results: mc=%0d ff=%0d fv=%b, expected mc=%0d ff=%0d fv=%b",
                     tag, mc_a, ff_a, fv_a, exp_mc, exp_ff, exp_fv);
        end
    endtask

    task automatic test_stuck_bit();
        int done_cyc;
        done_cyc = -1;
        start_b = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c == 1) start_b = 1'b0;
            if (done_b === 1'b1 && done_cyc < 0) done_cyc = c;
        end
        checks++;
        if (done_cyc != 17) begin
            errors++;
            $display("FAIL stuck_done: done cycle=%0d, expected 17", done_cyc);
        end
        checks++;
        if (mc_b !== 3'd2 || ff_b !== 2'd1 || fv_b !== 1'b1) begin
            errors++;
            $display("FAIL stuck_results: mc=%0d ff=%0d fv=%b, expected mc=2 ff=1 fv=1", mc_b, ff_b, fv_b);
        end
    endtask

    task automatic test_depth2();
        int done_cyc;
        g_in = 14'h0001;
        #1;
        checks++;
        if (g2_out !== 14'h2AAB) begin
            errors++;
            $display("FAIL golden_d2: got %0h, expected 2aab", g2_out);
        end
        checks++;
        if (g3_out !== 14'h3FFC) begin
            errors++;
            $display("FAIL golden_d3: got %0h, expected 3ffc", g3_out);
        end
        done_cyc = -1;
        @(negedge clk);
        start_c = 1'b1;
        for (int c = 1; c <= 1032; c++) begin
            @(negedge clk);
            if (c == 1) start_c = 1'b0;
            if (done_c === 1'b1 && done_cyc < 0) done_cyc = c;
        end
        checks++;
        if (done_cyc != 1025 || mc_c !== 9'd0 || fv_c !== 1'b0) begin
            errors++;
            $display("FAIL depth2_run: done cycle=%0d mc=%0d fv=%b, expected 1025 0 0", done_cyc, mc_c, fv_c);
        end
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        pulses = 0;
        fault_a = 1;
        @(negedge clk);
        start_a = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) start_a = 1'b0;
        end
        checks++;
        if (din_a !== 14'd3 || busy_a !== 1'b1 || mc_a !== 5'd1 || fv_a !== 1'b1 || ff_a !== 4'd1) begin
            errors++;
            $display("FAIL pre_reset: dut_in=%0h busy=%b mc=%0d fv=%b ff=%0d, expected 3 1 1 1 1",
                     din_a, busy_a, mc_a, fv_a, ff_a);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (din_a !== 14'h0 || busy_a !== 1'b0 || done_a !== 1'b0 || mc_a !== 5'd0 ||
            fv_a !== 1'b0 || ff_a !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: dut_in=%0h busy=%b done=%b mc=%0d fv=%b ff=%0d, expected all zero",
                     din_a, busy_a, done_a, mc_a, fv_a, ff_a);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 2) rst = 1'b0;
            if (done_a !== 1'b0 || busy_a !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_quiet: %0d cycles with done/busy set after reset, expected 0", pulses);
        end
        fault_a = -1;
        test_run_a(0, 0, 1'b0, "rerun");
    endtask

    task automatic test_back_to_back();
        int first_done;
        int second_done;
        int pulses;
        first_done = -1;
        second_done = -1;
        pulses = 0;
        @(negedge clk);
        start_d = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done_d === 1'b1) begin
                pulses++;
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
            if (c == 5) begin
                checks++;
                if (din_d !== 14'd2) begin
                    errors++;
                    $display("FAIL b2b_drive2: dut_in=%0h, expected 2", din_d);
                end
            end
            if (c == 7) begin
                checks++;
                if (din_d !== 14'd2 || busy_d !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_done_hold: dut_in=%0h busy=%b, expected 2 0", din_d, busy_d);
                end
            end
            if (c == 8) begin
                checks++;
                if (busy_d !== 1'b0 || done_d !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_idle: busy=%b done=%b, expected 0 0", busy_d, done_d);
                end
            end
            if (c == 9) begin
                checks++;
                if (busy_d !== 1'b1 || din_d !== 14'd0) begin
                    errors++;
                    $display("FAIL b2b_restart: busy=%b dut_in=%0h, expected 1 0", busy_d, din_d);
                end
            end
            case (c)
                1, 4, 9: start_d = 1'b0;
                3, 5:    start_d = 1'b1;
                default: ;
            endcase
        end
        checks++;
        if (first_done != 7 || second_done != 15 || pulses != 2) begin
            errors++;
            $display("FAIL b2b_done: first=%0d second=%0d pulses=%0d, expected 7 15 2",
                     first_done, second_done, pulses);
        end
        checks++;
        if (mc_d !== 2'd0 || fv_d !== 1'b0) begin
            errors++;
            $display("FAIL b2b_results: mc=%0d fv=%b, expected 0 0", mc_d, fv_d);
        end
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        start_d = 1'b0;
        g_in = 14'h0;
        test_reset();
        test_run_a(0, 0, 1'b0, "clean");
        fault_a = 5;
        test_run_a(1, 5, 1'b1, "fault5");
        fault_a = -1;
        test_stuck_bit();
        test_depth2();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
